// File: rtl/cardinal_router_port.sv
// cardinal_router_port: two-VC router port; VC ~polarity faces the link, VC polarity moves ib -> ob.
module cardinal_router_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        up_si,
  output logic        up_ri,
  input  logic [63:0] up_di,
  output logic        dn_so,
  input  logic        dn_ro,
  output logic [63:0] dn_do,
  output logic        polarity,
  output logic        vc_err,
  output logic [15:0] rx_count,
  output logic [15:0] tx_count
);
  logic [63:0] ib [2];
  logic [63:0] ob [2];
  logic [1:0]  ib_full, ob_full;
  logic        ext, offer, accept, xfer;
  always_comb begin
    ext    = ~polarity;
    up_ri  = ~ib_full[ext];
    offer  = up_si & up_ri;
    accept = offer & (up_di[63] == ext);
    vc_err = offer & (up_di[63] == polarity);
    xfer   = ib_full[polarity] & ~ob_full[polarity];
    dn_so  = ob_full[ext] & dn_ro;
    dn_do  = ob[ext];
  end
  // Accept/send touch VC ext, transfer touches VC polarity, so no buffer sees two writers.
  always_ff @(posedge clk) begin
    if (reset) begin
      polarity <= 1'b0;
      ib       <= '{default: '0};
      ob       <= '{default: '0};
      ib_full  <= '0;
      ob_full  <= '0;
      rx_count <= '0;
      tx_count <= '0;
    end else begin
      polarity <= ~polarity;
      if (accept) begin
        ib[ext]      <= up_di;
        ib_full[ext] <= 1'b1;
        rx_count     <= rx_count + 16'd1;
      end
      if (xfer) begin
        ob[polarity]      <= ib[polarity];
        ob_full[polarity] <= 1'b1;
        ib_full[polarity] <= 1'b0;
      end
      if (dn_so) begin
        ob_full[ext] <= 1'b0;
        tx_count     <= tx_count + 16'd1;
      end
    end
  end
endmodule
